fxp_accumulator: RTL and testbench



---
 rtl/fxp_pkg.sv | 23 ++
 rtl/fxp_saturate.sv | 31 +++
 rtl/fxp_accumulator.sv | 132 +++++++++++++
 tb/tb_fxp_accumulator.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/fxp_pkg.sv
// Shared types and constants for the Q2.6 fixed-point datapath.
package fxp_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_FRAC_W = 6;
    localparam int unsigned DEF_ACC_W  = 16;
    localparam int unsigned DEF_LEN_W  = 8;

    localparam int unsigned Q_INT_W  = 2;
    localparam int unsigned Q_FRAC_W = 6;
    localparam logic signed [7:0] Q_MAX = 8'sh7F;
    localparam logic signed [7:0] Q_MIN = 8'sh80;

    // Smallest accumulator that can sum 2^LEN_W-1 full-scale terms without wrapping.
    localparam int unsigned ACC_W_MIN = DEF_DATA_W + DEF_LEN_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/fxp_saturate.sv
// Clamp a wide signed value to the signed DATA_W range, flagging when clipping occurs.
module fxp_saturate #(
    parameter int unsigned ACC_W  = 16,
    parameter int unsigned DATA_W = 8
) (
    input  logic [ACC_W-1:0]  acc,
    output logic [DATA_W-1:0] sat_c,
    output logic              clip_c
);

    localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    logic [ACC_W-DATA_W:0] top_bits;
    logic                  fits;

    // Value fits when every bit above the output sign bit equals the sign.
    always_comb begin
        top_bits = acc[ACC_W-1:DATA_W-1];
        fits     = (&top_bits) | (~|top_bits);
        clip_c   = ~fits;
        if (fits) begin
            sat_c = acc[DATA_W-1:0];
        end else if (acc[ACC_W-1]) begin
            sat_c = SAT_MIN;
        end else begin
            sat_c = SAT_MAX;
        end
    end

endmodule

// File: rtl/fxp_accumulator.sv
// Sums a programmed number of Q2.6 products and returns a saturated result with sticky overflow.
module fxp_accumulator
    import fxp_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned FRAC_W = DEF_FRAC_W,
    parameter int unsigned ACC_W  = DEF_ACC_W,
    parameter int unsigned LEN_W  = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_ov,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_ov,
    output logic              busy
);

    localparam int unsigned EXT_W = ACC_W - DATA_W;

    if (ACC_W < DATA_W + LEN_W) begin : g_bad_acc_w
        $error("fxp_accumulator: ACC_W too narrow for DATA_W + LEN_W");
    end
    if (FRAC_W >= DATA_W) begin : g_bad_frac_w
        $error("fxp_accumulator: FRAC_W must be below DATA_W");
    end

    state_t             state, state_nxt;
    logic [ACC_W-1:0]   acc, acc_nxt;
    logic [LEN_W-1:0]   cnt, cnt_nxt;
    logic [LEN_W-1:0]   len_q, len_nxt;
    logic               ov_sticky, ov_nxt;
    logic [DATA_W-1:0]  odata_nxt;
    logic               oov_nxt;

    logic [ACC_W-1:0]   sum_c;
    logic [DATA_W-1:0]  sat_c;
    logic               clip_c;

    // Running sum including the beat currently on the input.
    assign sum_c = acc + {{EXT_W{in_data[DATA_W-1]}}, in_data};

    fxp_saturate #(
        .ACC_W  (ACC_W),
        .DATA_W (DATA_W)
    ) u_sat (
        .acc    (sum_c),
        .sat_c  (sat_c),
        .clip_c (clip_c)
    );

    // Status outputs decode straight from the state register.
    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            len_q     <= '0;
            ov_sticky <= 1'b0;
            out_data  <= '0;
            out_ov    <= 1'b0;
        end else begin
            state     <= state_nxt;
            acc       <= acc_nxt;
            cnt       <= cnt_nxt;
            len_q     <= len_nxt;
            ov_sticky <= ov_nxt;
            out_data  <= odata_nxt;
            out_ov    <= oov_nxt;
        end
    end

    // Next-state and datapath update; result captured on the edge that enters DONE.
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        len_nxt   = len_q;
        ov_nxt    = ov_sticky;
        odata_nxt = out_data;
        oov_nxt   = out_ov;
        case (state)
            IDLE: begin
                if (start) begin
                    len_nxt = len;
                    acc_nxt = '0;
                    cnt_nxt = '0;
                    ov_nxt  = 1'b0;
                    if (len == '0) begin
                        state_nxt = DONE;
                        odata_nxt = '0;
                        oov_nxt   = 1'b0;
                    end else begin
                        state_nxt = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    acc_nxt = sum_c;
                    ov_nxt  = ov_sticky | in_ov;
                    cnt_nxt = cnt + LEN_W'(1);
                    if (cnt == len_q - LEN_W'(1)) begin
                        state_nxt = DONE;
                        odata_nxt = sat_c;
                        oov_nxt   = ov_sticky | in_ov | clip_c;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fxp_accumulator.sv
// Directed scoreboard bench for fxp_accumulator.
module tb_fxp_accumulator;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] len;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_ov;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_ov;
    logic       busy;

    int nvec = 0;
    int nmis = 0;

    logic [8:0] sb[$];
    logic [7:0] vd[256];
    logic       vo[256];

    fxp_accumulator dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ov     (in_ov),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ov    (out_ov),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every result handshake.
    always @(negedge clk) begin
        if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", 32'(out_data), 32'hDEAD);
            end else begin
                logic [8:0] e;
                e = sb.pop_front();
                chk("out_data", 32'(out_data), 32'(e[8:1]));
                chk("out_ov", 32'(out_ov), 32'(e[0]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One accumulation run: optional 1-cycle gaps between beats, optional DONE hold.
    task automatic run(input int n, input bit gap, input int hold,
                       input logic [7:0] ed, input logic eo);
        sb.push_back({ed, eo});
        len   = 8'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (gap && i > 0) begin
                in_valid = 1'b0;
                in_data  = 8'h7F;
                in_ov    = 1'b1;
                tick();
            end
            in_valid = 1'b1;
            in_data  = vd[i];
            in_ov    = vo[i];
            begin
                int k = 0;
                while (in_ready !== 1'b1 && k < 10) begin
                    tick();
                    k++;
                end
                if (in_ready !== 1'b1) chk("in_ready_timeout", 32'(in_ready), 32'd1);
            end
            tick();
        end
        in_valid = 1'b0;
        in_ov    = 1'b0;
        in_data  = 8'h00;
        chk("latency_out_valid", 32'(out_valid), 32'd1);
        for (int h = 0; h < hold; h++) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", 32'(out_data), 32'(ed));
            chk("hold_ov", 32'(out_ov), 32'(eo));
            start = (h == 2);
            len   = 8'd3;
            tick();
            start = 1'b0;
        end
        out_ready = 1'b1;
        start     = 1'b1;
        len       = 8'd2;
        tick();
        start     = 1'b0;
        out_ready = 1'b0;
        chk("idle_after_handshake", 32'(busy), 32'd0);
    endtask

    task automatic set3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                        input logic oa, input logic ob, input logic oc);
        vd[0] = a; vd[1] = b; vd[2] = c;
        vo[0] = oa; vo[1] = ob; vo[2] = oc;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; len = 8'd0;
        in_valid = 1'b0; in_data = 8'h00; in_ov = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_ov", 32'(out_ov), 32'd0);
        rst = 1'b0;
        tick();

        set3(8'h40, 8'h20, 8'h00, 1'b0, 1'b0, 1'b0); run(2, 1'b0, 0, 8'h60, 1'b0);
        set3(8'h40, 8'h40, 8'h00, 1'b0, 1'b0, 1'b0); run(2, 1'b0, 0, 8'h7F, 1'b1);
        set3(8'hC0, 8'hC0, 8'h00, 1'b0, 1'b0, 1'b0); run(2, 1'b0, 0, 8'h80, 1'b0);
        set3(8'hC0, 8'hC0, 8'hFF, 1'b0, 1'b0, 1'b0); run(3, 1'b0, 0, 8'h80, 1'b1);
        set3(8'h10, 8'h10, 8'h10, 1'b0, 1'b1, 1'b0); run(3, 1'b0, 0, 8'h30, 1'b1);
        set3(8'h10, 8'h10, 8'h10, 1'b0, 1'b0, 1'b1); run(3, 1'b0, 0, 8'h30, 1'b1);

        // 0x10 + 0x20 - 0x10 + 0x08 = 0x28, gaps carry junk that must be ignored
        set3(8'h10, 8'h20, 8'hF0, 1'b0, 1'b0, 1'b0);
        vd[3] = 8'h08; vo[3] = 1'b0;
        run(4, 1'b1, 5, 8'h28, 1'b0);

        run(0, 1'b0, 0, 8'h00, 1'b0);

        for (int i = 0; i < 255; i++) begin
            vd[i] = 8'h80;
            vo[i] = 1'b0;
        end
        run(255, 1'b0, 0, 8'h80, 1'b1);

        // Abort a 4-beat run after two beats.
        len = 8'd4; start = 1'b1; tick(); start = 1'b0;
        in_valid = 1'b1; in_data = 8'h40; in_ov = 1'b1; tick();
        in_data = 8'h30; tick();
        in_valid = 1'b0; in_ov = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_out_data", 32'(out_data), 32'd0);
        chk("abort_out_ov", 32'(out_ov), 32'd0);
        tick();

        vd[0] = 8'h15; vo[0] = 1'b0;
        run(1, 1'b0, 0, 8'h15, 1'b0);

        tick();
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
